// File: rtl/siren_pkg.sv
// siren_pkg: shared states, divider width default and request priority encoder
package siren_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
  localparam int DIV_W_DEF = 16;
  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;
  // lowest set index wins; vld low when nothing requests
  function automatic pick_t pri_enc(input logic [7:0] r);
    pick_t p;
    p = '0;
    for (int i = 7; i >= 0; i--) if (r[i]) p = '{vld: 1'b1, idx: 3'(i)};
    return p;
  endfunction
endpackage

// File: rtl/siren_tone_arbiter_tone_divider.sv
// tone_divider: half-period counter that toggles the speaker on each reload
module tone_divider
  import siren_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             osc_CLK,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic [DIV_W-1:0] div_val,
  input  logic             mute,
  output logic             tone
);
  logic [DIV_W-1:0] div_cnt;
  // count down to zero, reload from the live divider and toggle unless muted; silent when not running
  always_ff @(posedge osc_CLK or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (load) begin
      div_cnt <= load_val;
      tone    <= 1'b0;
    end else if (run) begin
      div_cnt <= (div_cnt == '0) ? div_val : div_cnt - 1'b1;
      if (div_cnt == '0 && !mute) tone <= ~tone;
    end else
      tone <= 1'b0;
endmodule

// File: rtl/siren_tone_arbiter.sv
// siren_tone_arbiter: fixed-priority owner of the shared tone divider and speaker pin
module siren_tone_arbiter
  import siren_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int MIN_HOLD   = 65536,
  parameter int GAP_CYCLES = 4096
) (
  input  logic                   osc_CLK,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DIV_W-1:0] div_in,
  input  logic                   mute,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   pin20
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  state_t           state, state_nxt;
  logic [OW-1:0]    owner, owner_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic             load, run, leave;
  pick_t            pick;
  assign pick  = pri_enc(8'(req));
  assign leave = (hold_cnt == HW'(MIN_HOLD)) &&
                 (!req[owner] || |(req & ~({N_REQ{1'b1}} << owner)));
  assign busy  = (state != IDLE);
  // arbitration, hold/gap counting and grant selection
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_nxt = grant;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    load      = 1'b0;
    run       = 1'b0;
    case (state)
      IDLE:
        if (pick.vld) begin
          state_nxt = PLAY;
          owner_nxt = OW'(pick.idx);
          grant_nxt = N_REQ'(1) << pick.idx;
          hold_nxt  = '0;
          load      = 1'b1;
        end
      PLAY:
        if (leave) begin
          state_nxt = GAP;
          grant_nxt = '0;
          gap_nxt   = '0;
        end else begin
          run      = 1'b1;
          hold_nxt = (hold_cnt == HW'(MIN_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
        end
      GAP: begin
        gap_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state and bookkeeping registers
  always_ff @(posedge osc_CLK or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      grant    <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      grant    <= grant_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
    end
  tone_divider #(.DIV_W(DIV_W)) u_div (
    .osc_CLK (osc_CLK),
    .rst_n   (rst_n),
    .run     (run),
    .load    (load),
    .load_val(div_in[pick.idx*DIV_W +: DIV_W]),
    .div_val (div_in[owner*DIV_W +: DIV_W]),
    .mute    (mute),
    .tone    (pin20)
  );
endmodule

// File: tb/tb_siren_tone_arbiter.sv
// tb_siren_tone_arbiter: directed cycle-exact checks of arbitration, hold, gap, divider, mute and reset
module tb_siren_tone_arbiter;
  logic        osc_CLK, rst_n, mute, busy, pin20;
  logic [3:0]  req, grant;
  logic [31:0] div_in;
  int total = 0, bad = 0;

  siren_tone_arbiter #(.N_REQ(4), .DIV_W(8), .MIN_HOLD(8), .GAP_CYCLES(4)) dut (
    .osc_CLK(osc_CLK), .rst_n(rst_n), .req(req), .div_in(div_in), .mute(mute),
    .grant(grant), .busy(busy), .pin20(pin20)
  );

  initial osc_CLK = 1'b0;
  always #5 osc_CLK = ~osc_CLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge osc_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; req = '0; div_in = '0; mute = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pin", 32'(pin20), 0);
    step(2);
    rst_n = 1'b1;
    step();
    chk("idle_grant", 32'(grant), 0);
    // single source, divider 3, request dropped before hold expires
    req = 4'b0010; div_in[8 +: 8] = 8'd3;
    step();
    chk("s1_grant", 32'(grant), 32'b0010);
    chk("s1_busy", 32'(busy), 1);
    step(3);
    chk("s1_pin_e3", 32'(pin20), 0);
    step();
    chk("s1_pin_e4", 32'(pin20), 1);
    req = '0;
    step(3);
    chk("s1_pin_e7", 32'(pin20), 1);
    chk("s1_hold_grant", 32'(grant), 32'b0010);
    step();
    chk("s1_pin_e8", 32'(pin20), 0);
    chk("s1_grant_e8", 32'(grant), 32'b0010);
    step();
    chk("s1_rel_grant", 32'(grant), 0);
    chk("s1_rel_busy", 32'(busy), 1);
    chk("s1_rel_pin", 32'(pin20), 0);
    step(3);
    chk("s1_gap_busy", 32'(busy), 1);
    step();
    chk("s1_gap_end", 32'(busy), 0);
    // two requests in IDLE: index 1 beats index 3
    req = 4'b1010; div_in[24 +: 8] = 8'd5;
    step();
    chk("pr_grant", 32'(grant), 32'b0010);
    req = 4'b1000;
    step(8);
    chk("pr_hold", 32'(grant), 32'b0010);
    step();
    chk("pr_rel", 32'(grant), 0);
    chk("pr_rel_busy", 32'(busy), 1);
    step(4);
    chk("pr_gap_busy", 32'(busy), 0);
    chk("pr_gap_grant", 32'(grant), 0);
    step();
    chk("pr_grant3", 32'(grant), 32'b1000);
    req = '0;
    step(13);
    chk("pr_idle", 32'(busy), 0);
    // preemption waits for the minimum hold
    req = 4'b0100; div_in[16 +: 8] = 8'd2; div_in[0 +: 8] = 8'd3;
    step();
    chk("pe_grant2", 32'(grant), 32'b0100);
    step(2);
    req = 4'b0101;
    step(6);
    chk("pe_hold", 32'(grant), 32'b0100);
    step();
    chk("pe_rel", 32'(grant), 0);
    chk("pe_rel_busy", 32'(busy), 1);
    step(4);
    chk("pe_gap_end", 32'(busy), 0);
    step();
    chk("pe_grant0", 32'(grant), 32'b0001);
    req = 4'b0001;
    // live ramp: change 3 -> 7 mid-count
    step(4);
    chk("rp_pin_e4", 32'(pin20), 1);
    step();
    div_in[0 +: 8] = 8'd7;
    step(2);
    chk("rp_pin_e7", 32'(pin20), 1);
    step();
    chk("rp_pin_e8", 32'(pin20), 0);
    step(7);
    chk("rp_pin_e15", 32'(pin20), 0);
    step();
    chk("rp_pin_e16", 32'(pin20), 1);
    chk("rp_grant", 32'(grant), 32'b0001);
    // divider 0 toggles every cycle, mute freezes the pin
    div_in[0 +: 8] = 8'd0;
    step(7);
    chk("mu_pin_e23", 32'(pin20), 1);
    step();
    chk("mu_pin_e24", 32'(pin20), 0);
    step();
    chk("mu_pin_e25", 32'(pin20), 1);
    mute = 1'b1;
    step();
    chk("mu_frz1", 32'(pin20), 1);
    step();
    chk("mu_frz2", 32'(pin20), 1);
    chk("mu_grant", 32'(grant), 32'b0001);
    mute = 1'b0;
    step();
    chk("mu_resume", 32'(pin20), 0);
    step();
    chk("mu_pin_e29", 32'(pin20), 1);
    // asynchronous reset mid-PLAY
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pin", 32'(pin20), 0);
    chk("ar_grant", 32'(grant), 0);
    chk("ar_busy", 32'(busy), 0);
    step();
    chk("ar_held", 32'(grant), 0);
    rst_n = 1'b1;
    step();
    chk("ar_regrant", 32'(grant), 32'b0001);
    chk("ar_busy2", 32'(busy), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
